// File: rtl/policy_gen_if.sv
// Request/result bundle between the control unit and the move generator.
//
// Handshake: the requester raises en_policygen; it is taken only while the
// generator is idle (busy low). The generator answers with a single-cycle
// action_valid pulse that qualifies action; there is no back-pressure, so
// the requester must be able to consume the result in that cycle. action
// keeps its value after the pulse until the next result replaces it.
interface policy_gen_if;
    logic       en_policygen;
    logic [8:0] board_agent;
    logic [8:0] board_player;
    logic [3:0] action;
    logic       action_valid;
    logic       busy;

    modport master (
        output en_policygen, board_agent, board_player,
        input  action, action_valid, busy
    );

    modport slave (
        input  en_policygen, board_agent, board_player,
        output action, action_valid, busy
    );
endinterface

// File: rtl/policy_gen.sv
// Tic-tac-toe move generator. Snapshots both boards on request, then walks
// the eight lines looking for a winning move, then for a blocking move, then
// walks a fixed cell preference order, one step per clock. The first hit
// (or a full board) ends the request with a registered one-cycle result.
module policy_gen #(
    parameter logic [3:0] NO_MOVE = 4'hF
) (
    input  logic          clock,
    input  logic          reset_n,
    policy_gen_if.slave   bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_WIN   = 2'd1,
        SCAN_BLOCK = 2'd2,
        SCAN_PREF  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [3:0] index, index_n;
    logic [8:0] snap_agent, snap_agent_n;
    logic [8:0] snap_player, snap_player_n;
    logic [3:0] action_q, action_n;
    logic       valid_q, valid_n;
    logic       busy_q, busy_n;

    logic [3:0] cell0, cell1, cell2;
    logic [3:0] pref_cell;
    logic [8:0] occupied, own;
    logic [1:0] own_cnt, empty_cnt;
    logic       line_hit;
    logic [3:0] empty_cell;
    logic       pref_empty;

    assign bus.action       = action_q;
    assign bus.action_valid = valid_q;
    assign bus.busy         = busy_q;
    assign dbg_state        = state;

    // Line table: the three cells of line index[2:0], row-major numbering.
    always_comb begin
        cell0 = 4'd0;
        cell1 = 4'd0;
        cell2 = 4'd0;
        case (index[2:0])
            3'd0: begin cell0 = 4'd0; cell1 = 4'd1; cell2 = 4'd2; end
            3'd1: begin cell0 = 4'd3; cell1 = 4'd4; cell2 = 4'd5; end
            3'd2: begin cell0 = 4'd6; cell1 = 4'd7; cell2 = 4'd8; end
            3'd3: begin cell0 = 4'd0; cell1 = 4'd3; cell2 = 4'd6; end
            3'd4: begin cell0 = 4'd1; cell1 = 4'd4; cell2 = 4'd7; end
            3'd5: begin cell0 = 4'd2; cell1 = 4'd5; cell2 = 4'd8; end
            3'd6: begin cell0 = 4'd0; cell1 = 4'd4; cell2 = 4'd8; end
            default: begin cell0 = 4'd2; cell1 = 4'd4; cell2 = 4'd6; end
        endcase
    end

    // Preference order: centre, corners, then edges.
    always_comb begin
        pref_cell = 4'd0;
        case (index)
            4'd0: pref_cell = 4'd4;
            4'd1: pref_cell = 4'd0;
            4'd2: pref_cell = 4'd2;
            4'd3: pref_cell = 4'd6;
            4'd4: pref_cell = 4'd8;
            4'd5: pref_cell = 4'd1;
            4'd6: pref_cell = 4'd3;
            4'd7: pref_cell = 4'd5;
            4'd8: pref_cell = 4'd7;
            default: pref_cell = 4'd0;
        endcase
    end

    // Evaluate the current line against the side being scanned. A cell
    // claimed by both maps is occupied, never empty.
    always_comb begin
        occupied   = snap_agent | snap_player;
        own        = (state == SCAN_BLOCK) ? snap_player : snap_agent;
        own_cnt    = {1'b0, own[cell0]} + {1'b0, own[cell1]} + {1'b0, own[cell2]};
        empty_cnt  = {1'b0, ~occupied[cell0]} + {1'b0, ~occupied[cell1]}
                   + {1'b0, ~occupied[cell2]};
        line_hit   = (own_cnt == 2'd2) && (empty_cnt == 2'd1);
        if (!occupied[cell0])
            empty_cell = cell0;
        else if (!occupied[cell1])
            empty_cell = cell1;
        else
            empty_cell = cell2;
        pref_empty = ~occupied[pref_cell];
    end

    // Next-state and result logic for the scan sequence.
    always_comb begin
        state_n       = state;
        index_n       = index;
        snap_agent_n  = snap_agent;
        snap_player_n = snap_player;
        action_n      = action_q;
        valid_n       = 1'b0;
        busy_n        = busy_q;
        case (state)
            IDLE: begin
                if (bus.en_policygen) begin
                    snap_agent_n  = bus.board_agent;
                    snap_player_n = bus.board_player;
                    index_n       = 4'd0;
                    state_n       = SCAN_WIN;
                    busy_n        = 1'b1;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (line_hit) begin
                    action_n = empty_cell;
                    valid_n  = 1'b1;
                    busy_n   = 1'b0;
                    index_n  = 4'd0;
                    state_n  = IDLE;
                end else if (index == 4'd7) begin
                    index_n = 4'd0;
                    state_n = (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_PREF;
                end else begin
                    index_n = index + 4'd1;
                end
            end
            SCAN_PREF: begin
                if (pref_empty || index == 4'd8) begin
                    action_n = pref_empty ? pref_cell : NO_MOVE;
                    valid_n  = 1'b1;
                    busy_n   = 1'b0;
                    index_n  = 4'd0;
                    state_n  = IDLE;
                end else begin
                    index_n = index + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                index_n = 4'd0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, counter, snapshots and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            index       <= 4'd0;
            snap_agent  <= 9'd0;
            snap_player <= 9'd0;
            action_q    <= NO_MOVE;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            index       <= index_n;
            snap_agent  <= snap_agent_n;
            snap_player <= snap_player_n;
            action_q    <= action_n;
            valid_q     <= valid_n;
            busy_q      <= busy_n;
        end
    end

endmodule
